// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared definitions for the LCD message arbiter: FSM state
//                encoding, default timing constants, LCD instruction width
//                and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

  // Arbiter FSM state encoding
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_START = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_ACK   = 3'd3;
  localparam logic [2:0] c_ST_ABORT = 3'd4;
  localparam logic [2:0] c_ST_GAP   = 3'd5;

  // Default timing (50 MHz system clock)
  localparam int C_INIT_HOLD   = 2;
  localparam int C_GAP_CYC     = 1000;
  localparam int C_TIMEOUT_CYC = 2000000;

  // Width of one LCD instruction word on the sequencer interface
  localparam int C_LCD_INSTR_W = 11;

  // One counter is shared by START, WAIT and GAP, so it must be wide enough
  // for the largest terminal count of the three.
  function automatic int cnt_width(input int a, input int b, input int c);
    int w;
    w = $clog2(a);
    if ($clog2(b) > w) w = $clog2(b);
    if ($clog2(c) > w) w = $clog2(c);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request bit scanning i_ptr, i_ptr+1, ... modulo N_REQ.
//  Revision    : 1.0  initial release
//  Ports       : i_req   [N_REQ]  request vector
//                i_ptr   [SEL_W]  scan start index (always < N_REQ)
//                o_found          at least one request set
//                o_idx   [SEL_W]  index of the winning request
// ============================================================================
module lcd_rr_pick #(
  parameter int N_REQ = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  localparam logic [SEL_W:0] c_NREQ = (SEL_W+1)'(N_REQ);

  // Rotate so that bit 0 corresponds to the requester at i_ptr.
  logic [N_REQ-1:0] w_rot;
  logic [SEL_W:0]   w_sum;

  assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

  // Scan from the far end down so the lowest rotated position wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        w_sum   = {1'b0, i_ptr} + (SEL_W+1)'(k);
        o_idx   = (w_sum >= c_NREQ) ? SEL_W'(w_sum - c_NREQ) : SEL_W'(w_sum);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_msg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_msg_arbiter
//  Description : Round-robin scheduler sharing one LCD instruction sequencer
//                between several message requesters, with a DONE watchdog
//                that resets a hung sequencer.
//  Revision    : 1.0  initial release
//  Ports       : clk              system clock
//                reset            asynchronous active-low reset
//                req      [N_REQ] level requests, held until ack
//                lcd_done         sequencer DONE (level)
//                lcd_init         start strobe, INIT_HOLD cycles
//                lcd_rst          sequencer reset, watchdog recovery only
//                msg_sel  [SEL_W] granted index, steers the message mux
//                grant    [N_REQ] one-hot grant for the whole transaction
//                ack      [N_REQ] one-cycle completion/abort pulse
//                err              one-cycle pulse with ack on timeout abort
//                busy             high in every state except IDLE
// ============================================================================
module lcd_msg_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SEL_W       = 2,
  parameter int INIT_HOLD   = C_INIT_HOLD,
  parameter int GAP_CYC     = C_GAP_CYC,
  parameter int TIMEOUT_CYC = C_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             lcd_done,
  output logic             lcd_init,
  output logic             lcd_rst,
  output logic [SEL_W-1:0] msg_sel,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] ack,
  output logic             err,
  output logic             busy
);

  localparam int CNT_W = cnt_width(INIT_HOLD, GAP_CYC, TIMEOUT_CYC);

  localparam logic [CNT_W-1:0] c_INIT_LAST = CNT_W'(INIT_HOLD - 1);
  localparam logic [CNT_W-1:0] c_TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [SEL_W-1:0] c_SEL_LAST  = SEL_W'(N_REQ - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_grant;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic             r_done_q;

  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic             w_rise;
  logic             w_ack_cyc;
  logic             w_abort_end;
  logic [SEL_W-1:0] w_ptr_nxt;

  lcd_rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // DONE is a level that may still be high from the previous message; only a
  // low-to-high transition while waiting counts as completion.
  assign w_rise = lcd_done & ~r_done_q;

  // ABORT lasts two cycles; bit 0 of the shared counter marks the second.
  assign w_abort_end = (r_state == c_ST_ABORT) && r_cnt[0];
  assign w_ack_cyc   = (r_state == c_ST_ACK) || w_abort_end;
  assign w_ptr_nxt   = (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;

  assign lcd_init = (r_state == c_ST_START);
  assign lcd_rst  = (r_state == c_ST_ABORT);
  assign msg_sel  = r_sel;
  assign grant    = r_grant;
  assign ack      = w_ack_cyc ? r_grant : '0;
  assign err      = w_abort_end;
  assign busy     = (r_state != c_ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_ST_IDLE;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_sel    <= '0;
      r_ptr    <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= lcd_done;
      case (r_state)
        c_ST_IDLE: begin
          if (w_found) begin
            r_state <= c_ST_START;
            r_grant <= N_REQ'(1) << w_idx;
            r_sel   <= w_idx;
            r_cnt   <= '0;
          end
        end
        c_ST_START: begin
          if (r_cnt == c_INIT_LAST) begin
            r_state <= c_ST_WAIT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_WAIT: begin
          // An edge on the terminal cycle still counts as completion.
          if (w_rise) begin
            r_state <= c_ST_ACK;
            r_cnt   <= '0;
          end else if (r_cnt == c_TO_LAST) begin
            r_state <= c_ST_ABORT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_ACK: begin
          r_state <= c_ST_GAP;
          r_grant <= '0;
          r_sel   <= '0;
          r_ptr   <= w_ptr_nxt;
          r_cnt   <= '0;
        end
        c_ST_ABORT: begin
          if (r_cnt[0]) begin
            r_state <= c_ST_GAP;
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_cnt   <= '0;
          r_grant <= '0;
          r_sel   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lcd_msg_arbiter.md
Name: lcd_msg_arbiter

Overview:
- Round-robin arbiter/scheduler that shares the single LCD instruction sequencer between several message requesters (RFID status, slot status, error banner).
- Selects one requester and drives the message-select index that steers the upstream message ROM/mux onto the sequencer's instruction and count inputs.
- Pulses the sequencer's init, waits for its DONE, then acknowledges the requester.
- Recovers from a hung sequencer with a watchdog that resets the sequencer.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SEL_W, 2, width of msg_sel; must satisfy 2**SEL_W >= N_REQ.
- INIT_HOLD, 2, cycles lcd_init is held high per message (>=1).
- GAP_CYC, 1000, minimum idle cycles between end of one message and next init.
- TIMEOUT_CYC, 2000000, max cycles from init deassert to DONE rising (40 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester level request; held until matching ack.
- lcd_done  in  1  DONE from LCD sequencer (level).
- lcd_init  out  1  start strobe to sequencer.
- lcd_rst  out  1  active-high reset to sequencer (watchdog recovery only).
- msg_sel  out  SEL_W  index of granted requester; steers message mux.
- grant  out  N_REQ  one-hot, active for whole transaction.
- ack  out  N_REQ  one-cycle pulse on completion or abort.
- err  out  1  one-cycle pulse coincident with ack on timeout abort.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE, rr_ptr=0, all counters 0. lcd_init=0, lcd_rst=0, msg_sel=0, grant=0, ack=0, err=0, busy=0. Reset mid-transaction aborts silently: no ack issued.
- States: IDLE, START, WAIT, ACK, ABORT, GAP.
- IDLE: if any req bit is set, pick first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ. Next cycle: grant[i]=1, msg_sel=i, enter START. Grant stays stable until leaving ACK/ABORT.
- START: lcd_init=1 for exactly INIT_HOLD cycles, then go to WAIT.
- msg_sel is valid from the first START cycle; the mux is combinational, so the sequencer sees a stable message before init.
- WAIT: the timeout counter counts from 0.
  - Completion is a rising edge of lcd_done (registered previous value). A stale high DONE from the prior message is ignored.
  - Edge seen -> ACK.
  - Counter reaches TIMEOUT_CYC-1 with no edge -> ABORT.
  - Edge and timeout in the same cycle: edge wins (ACK).
- ACK: ack[i]=1 for 1 cycle, grant cleared, rr_ptr=(i+1) mod N_REQ, go to GAP.
- ABORT: lcd_rst=1 for 2 cycles. On the second cycle: ack[i]=1, err=1, grant cleared, rr_ptr advanced. Then go to GAP.
- GAP: count GAP_CYC cycles with outputs idle, then go to IDLE. New requests are only sampled in IDLE.
- Requester drops req while granted: the transaction still completes and ack is still pulsed (message already started).
- Total latency, req set in IDLE to first lcd_init high: 1 cycle.
- Fairness: any continuously asserted req is served within N_REQ-1 other transactions.
- Counter widths: $clog2 of the respective parameter. No wrap is possible because transitions occur at terminal count.

Decomposition:
- Shared package lcd_pkg: state encoding constants, default timing constants (INIT_HOLD, GAP_CYC, TIMEOUT_CYC), and the 11-bit LCD instruction word width.
- One natural sub-module: lcd_rr_pick. Combinational round-robin priority picker; inputs req and rr_ptr, outputs a found flag and the index.
- FSM, counters and edge detector stay in lcd_msg_arbiter.

Test Plan (GAP_CYC=10, TIMEOUT_CYC=50, N_REQ=4):
- Reset then req=0001; DONE rises 20 cycles after init falls:
  - lcd_init high 2 cycles, msg_sel=0, grant=0001.
  - ack=0001 pulse the cycle after DONE rise; busy low after GAP.
- req=1111 held, each DONE answered in 5 cycles: grants in order 0,1,2,3,0, each separated by ≥10 idle cycles.
- lcd_done held high from a prior message, req=0100: no ack until DONE falls and rises again. Proves edge detection.
- req=0010, DONE never rises:
  - ABORT 50 cycles after init falls; lcd_rst high 2 cycles.
  - ack=0010 with err=1; rr_ptr=2.
- Assert reset low during WAIT for req=1000: all outputs 0 immediately (async), no ack. After release, req still high -> re-granted.
- DONE rise on exactly the timeout terminal cycle: ack pulses with err=0 and lcd_rst never asserts.
